// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, immediate-select encoding and
// fetch-unit FSM states, used by the fetch unit and the immediate generator.
package cpu_pkg;

  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
  } ifu_state_e;

  function automatic imm_sel_e imm_sel_of(input logic [6:0] opcode);
    imm_sel_e sel;
    case (opcode)
      OPC_STORE:  sel = IMM_S;
      OPC_BRANCH: sel = IMM_B;
      OPC_JAL:    sel = IMM_J;
      default:    sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Fetch instruction buffer: circular FIFO of {instr, pc}; flush empties it
// and overrides any push or pop in the same cycle.
module ifu_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [31:0]            push_instr,
  input  logic [31:0]            push_pc,
  input  logic                   pop,
  input  logic                   flush,
  output logic [31:0]            head_instr,
  output logic [31:0]            head_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full buffer is legal only when the head leaves this cycle.
  assign do_pop     = pop && (count_q != '0);
  assign do_push    = push && ((count_q != FULL) || do_pop);
  assign head_instr = instr_mem[rd_q];
  assign head_pc    = pc_mem[rd_q];
  assign count      = count_q;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + PTR_W'(1);
      if (do_pop)  rd_d = rd_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      instr_mem[wr_q] <= push_instr;
      pc_mem[wr_q]    <= push_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: pc sequencing, single-outstanding memory request,
// redirect handling and decode handshake in front of an ifu_fifo buffer.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic [1:0]  id_imm_sel,
  output logic        id_imm_sign
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

  ifu_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             outs_q, outs_d;
  logic [CNT_W-1:0] fifo_count;
  logic [31:0]      head_instr, head_pc;
  logic             running, room, accept, push, pop;

  assign running        = (state_q == ST_RUN);
  assign room           = (fifo_count + CNT_W'(outs_q)) < DEPTH_CNT;
  assign imem_req_valid = running && !redirect_valid && room;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  // Responses are accepted only for a live request; anything else is stale.
  assign push           = running && outs_q && imem_rsp_valid && !redirect_valid;

  assign id_valid    = (fifo_count != '0);
  assign pop         = id_valid && id_ready;
  assign id_instr    = id_valid ? head_instr : '0;
  assign id_pc       = id_valid ? head_pc : '0;
  assign id_imm_sel  = imm_sel_of(id_instr[6:0]);
  assign id_imm_sign = 1'b1;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outs_d  = outs_q;
    if (outs_q && imem_rsp_valid) outs_d = 1'b0;
    if (accept) begin
      outs_d = 1'b1;
      pc_d   = pc_q + 32'd4;
    end
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_FLUSH: if (!outs_d) state_d = ST_RUN;
      default:  state_d = state_q;
    endcase
    // A request still in flight past the redirect must be drained in FLUSH.
    if (redirect_valid) begin
      pc_d    = {redirect_target[31:2], 2'b00};
      state_d = outs_d ? ST_FLUSH : ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      outs_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outs_q  <= outs_d;
    end
  end

  ifu_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_instr (imem_rsp_data),
    .push_pc    (pc_q - 32'd4),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: randomized traffic against a queue-based
// reference model, plus directed scenarios with hand-computed expectations.
module tb_instr_fetch_unit;

  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;
  logic [1:0]  id_imm_sel;
  logic        id_imm_sign;

  instr_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_ready        (id_ready),
    .id_imm_sel      (id_imm_sel),
    .id_imm_sign     (id_imm_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state (valid for the upcoming cycle)
  bit          m_boot;
  logic [31:0] m_pc;
  bit          m_outs;
  logic [31:0] m_outs_pc;
  logic [31:0] q_instr [$];
  logic [31:0] q_pc    [$];

  // Memory responder and samples of the last completed cycle
  bit          acc_last;
  logic [31:0] acc_addr;
  bit          spur_en;
  logic        s_reqv, s_idv, s_acc;
  logic [31:0] s_addr, s_idpc, s_idinstr;
  logic [1:0]  s_imm;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    case (a)
      32'h0000_0200: w = 32'hFE00_0EE3;
      32'h0000_0204: w = 32'h0000_006F;
      32'h0000_0208: w = 32'h0011_2023;
      32'h0000_020C: w = 32'h0000_0013;
      default: begin
        w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
        case (a[4:2])
          3'd0:    w[6:0] = 7'h23;
          3'd1:    w[6:0] = 7'h63;
          3'd2:    w[6:0] = 7'h6F;
          3'd3:    w[6:0] = 7'h13;
          3'd4:    w[6:0] = 7'h33;
          default: w[6:0] = 7'h03;
        endcase
      end
    endcase
    return w;
  endfunction

  function automatic logic [1:0] exp_imm(input logic [31:0] w);
    case (w[6:0])
      7'h23:   return 2'b01;
      7'h63:   return 2'b10;
      7'h6F:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_boot = 1'b1;
    m_pc   = RESET_PC;
    m_outs = 1'b0;
    q_instr.delete();
    q_pc.delete();
    acc_last = 1'b0;
  endtask

  // Called at a falling edge with ready/id_ready/redirect already driven.
  task automatic cycle();
    bit exp_req, exp_idv, do_pop;
    imem_rsp_valid = acc_last || (spur_en && ($urandom_range(0, 9) == 0));
    imem_rsp_data  = acc_last ? mem_word(acc_addr) : $urandom();
    #1;
    exp_req = !m_boot && !redirect_valid && ((q_pc.size() + int'(m_outs)) < BUF_DEPTH);
    exp_idv = (q_pc.size() != 0);
    check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
    if (exp_req) check("req_addr", imem_req_addr, m_pc);
    check("id_valid", {31'd0, id_valid}, {31'd0, exp_idv});
    if (exp_idv) begin
      check("id_instr", id_instr, q_instr[0]);
      check("id_pc", id_pc, q_pc[0]);
      check("id_imm_sel", {30'd0, id_imm_sel}, {30'd0, exp_imm(q_instr[0])});
      check("id_imm_sign", {31'd0, id_imm_sign}, 32'd1);
    end
    s_reqv = imem_req_valid;  s_addr = imem_req_addr;
    s_idv = id_valid;  s_idpc = id_pc;  s_idinstr = id_instr;  s_imm = id_imm_sel;
    s_acc = imem_req_valid && imem_req_ready;
    acc_last = s_acc;
    acc_addr = imem_req_addr;
    do_pop = exp_idv && id_ready;
    if (redirect_valid) begin
      q_instr.delete();
      q_pc.delete();
      m_pc   = {redirect_target[31:2], 2'b00};
      m_outs = 1'b0;
    end else begin
      if (do_pop) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (m_outs) begin
        q_instr.push_back(mem_word(m_outs_pc));
        q_pc.push_back(m_outs_pc);
      end
      if (exp_req && imem_req_ready) begin
        m_outs    = 1'b1;
        m_outs_pc = m_pc;
        m_pc      = m_pc + 32'd4;
      end else begin
        m_outs = 1'b0;
      end
    end
    m_boot = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    check({tag, "_id_instr"}, id_instr, 32'd0);
    check({tag, "_id_pc"}, id_pc, 32'd0);
    check({tag, "_imm_sel"}, {30'd0, id_imm_sel}, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid  = 1'b1;
    redirect_target = tgt;
    cycle();
    redirect_valid  = 1'b0;
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_target = $urandom();
        1:       redirect_target = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
        2:       redirect_target = 32'h0000_0100 | ($urandom() & 32'hFF);
        default: redirect_target = 32'h0000_0103;
      endcase
      cycle();
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    int acc_cnt, seen, hs;
    logic [31:0] hs_pc [3];
    rst_n = 1'b0;  imem_req_ready = 1'b1;  imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;  redirect_valid = 1'b0;  redirect_target = '0;
    id_ready = 1'b1;  spur_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Reset release: BOOT cycle, first request in cycle 2, first word in cycle 4
    rst_n = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cycle();
      if (c == 1) check("boot_no_req", {31'd0, s_reqv}, 32'd0);
      if (c == 2) begin
        check("first_req_valid", {31'd0, s_reqv}, 32'd1);
        check("first_req_addr", s_addr, 32'h0);
      end
      if (c == 4) begin
        check("first_id_valid", {31'd0, s_idv}, 32'd1);
        check("first_id_pc", s_idpc, 32'h0);
      end
      if (c == 5) check("second_id_pc", s_idpc, 32'h4);
      if (c == 7) check("third_id_pc", s_idpc, 32'h8);
    end

    // Decode stall: buffer fills to BUF_DEPTH and fetch stops
    id_ready = 1'b0;
    redirect_to(32'h0000_0300);
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_acc) acc_cnt++;
      if (i >= 2) begin
        check("stall_id_valid", {31'd0, s_idv}, 32'd1);
        check("stall_id_pc", s_idpc, 32'h300);
        check("stall_id_instr", s_idinstr, mem_word(32'h300));
      end
    end
    check("stall_accepts", acc_cnt, BUF_DEPTH);
    check("stall_req_low", {31'd0, s_reqv}, 32'd0);
    id_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 20 && hs < 3; i++) begin
      cycle();
      if (s_idv) begin
        hs_pc[hs] = s_idpc;
        hs++;
      end
    end
    check("release_handshakes", hs, 3);
    if (hs == 3) begin
      check("release_pc0", hs_pc[0], 32'h300);
      check("release_pc1", hs_pc[1], 32'h304);
      check("release_pc2", hs_pc[2], 32'h308);
    end

    // Redirect while a request is outstanding
    for (int i = 0; i < 10 && !m_outs; i++) cycle();
    check("wait_outstanding", {31'd0, m_outs}, 32'd1);
    redirect_to(32'h0000_0103);
    cycle();  check("redir_gap1", {31'd0, s_idv}, 32'd0);
    cycle();  check("redir_gap2", {31'd0, s_idv}, 32'd0);
    cycle();
    check("redir_id_valid", {31'd0, s_idv}, 32'd1);
    check("redir_id_pc", s_idpc, 32'h100);

    // Redirect coinciding with a decode handshake and a memory response
    for (int i = 0; i < 10 && !(m_outs && q_pc.size() != 0); i++) cycle();
    check("wait_hs_rsp", {31'd0, (m_outs && q_pc.size() != 0)}, 32'd1);
    redirect_to(32'h0000_0400);
    cycle();
    check("redir2_empty", {31'd0, s_idv}, 32'd0);
    check("redir2_req_valid", {31'd0, s_reqv}, 32'd1);
    check("redir2_req_addr", s_addr, 32'h400);

    // Immediate-select decode
    redirect_to(32'h0000_0200);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_idv) begin
        case (s_idpc)
          32'h200: begin check("imm_beq", {30'd0, s_imm}, 32'd2);  seen++; end
          32'h204: begin check("imm_jal", {30'd0, s_imm}, 32'd3);  seen++; end
          32'h208: begin check("imm_sw", {30'd0, s_imm}, 32'd1);   seen++; end
          32'h20C: begin check("imm_addi", {30'd0, s_imm}, 32'd0); seen++; end
          default: ;
        endcase
      end
    end
    check("imm_seen", seen, 4);

    // pc wrap at the top of the address space
    redirect_to(32'hFFFF_FFFC);
    cycle();
    check("wrap_req_hi", s_addr, 32'hFFFF_FFFC);
    cycle();
    check("wrap_req_valid", {31'd0, s_reqv}, 32'd1);
    check("wrap_req_addr", s_addr, 32'h0);

    spur_en = 1'b1;
    rand_phase(3000);

    // Reset in the middle of traffic; a late response must be ignored
    imem_req_ready = 1'b1;  id_ready = 1'b1;  redirect_valid = 1'b0;
    for (int i = 0; i < 10 && !m_outs; i++) cycle();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    spur_en  = 1'b0;
    acc_last = 1'b1;
    acc_addr = 32'hDEAD_0000;
    for (int c = 1; c <= 4; c++) cycle();
    check("postreset_id_pc", s_idpc, RESET_PC);
    check("postreset_id_instr", s_idinstr, mem_word(RESET_PC));

    spur_en = 1'b1;
    rand_phase(800);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
